// File: rtl/ls_ctrl_pkg.sv
// Shared widths, opcodes and state type for the load/store execution stage.
package ls_ctrl_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;
    localparam int OP_WIDTH   = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [OP_WIDTH-1:0] op_t;

    localparam op_t OP_LB  = 6'h10;
    localparam op_t OP_LH  = 6'h11;
    localparam op_t OP_LW  = 6'h12;
    localparam op_t OP_LBU = 6'h13;
    localparam op_t OP_LHU = 6'h14;
    localparam op_t OP_SB  = 6'h18;
    localparam op_t OP_SH  = 6'h19;
    localparam op_t OP_SW  = 6'h1A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    function automatic logic is_store(op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Bytes minus one, as MemCtrl expects.
    function automatic logic [1:0] op_size(op_t op);
        logic [1:0] s;
        case (op)
            OP_LB, OP_LBU, OP_SB: s = 2'd0;
            OP_LH, OP_LHU, OP_SH: s = 2'd1;
            default:              s = 2'd3;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/ls_ctrl_if.sv
// LSBuffer issue, MemCtrl data port and LS CDB channel of the LS stage.
interface ls_ctrl_if;
    import ls_ctrl_pkg::*;

    logic                  rdy_lsb_in;
    op_t                   opcode_lsb_in;
    logic [DATA_WIDTH-1:0] vj_lsb_in;
    logic [DATA_WIDTH-1:0] vk_lsb_in;
    logic [DATA_WIDTH-1:0] imm_lsb_in;
    logic [ROB_WIDTH-1:0]  rob_id_lsb_in;
    logic                  idle_lsb_out;

    logic                  valid_mc_out;
    logic                  wr_mc_out;
    logic [DATA_WIDTH-1:0] addr_mc_out;
    logic [1:0]            size_mc_out;
    logic [DATA_WIDTH-1:0] wdata_mc_out;
    logic                  done_mc_in;
    logic [DATA_WIDTH-1:0] rdata_mc_in;

    logic                  rdy_cdb_out;
    logic [DATA_WIDTH-1:0] result_cdb_out;
    logic [ROB_WIDTH-1:0]  rob_id_cdb_out;

    modport master (
        input  rdy_lsb_in, opcode_lsb_in, vj_lsb_in, vk_lsb_in,
        input  imm_lsb_in, rob_id_lsb_in, done_mc_in, rdata_mc_in,
        output idle_lsb_out, valid_mc_out, wr_mc_out, addr_mc_out,
        output size_mc_out, wdata_mc_out, rdy_cdb_out,
        output result_cdb_out, rob_id_cdb_out
    );

    modport slave (
        output rdy_lsb_in, opcode_lsb_in, vj_lsb_in, vk_lsb_in,
        output imm_lsb_in, rob_id_lsb_in, done_mc_in, rdata_mc_in,
        input  idle_lsb_out, valid_mc_out, wr_mc_out, addr_mc_out,
        input  size_mc_out, wdata_mc_out, rdy_cdb_out,
        input  result_cdb_out, rob_id_cdb_out
    );
endinterface

// File: rtl/ls_ctrl_extend.sv
// Load result formatting: sign/zero extension of MemCtrl read data.
module ls_ctrl_extend
    import ls_ctrl_pkg::*;
(
    input  op_t                   i_op,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_result
);
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_LB:   o_result = {{24{i_rdata[7]}}, i_rdata[7:0]};
            OP_LH:   o_result = {{16{i_rdata[15]}}, i_rdata[15:0]};
            OP_LBU:  o_result = {24'd0, i_rdata[7:0]};
            OP_LHU:  o_result = {16'd0, i_rdata[15:0]};
            OP_LW:   o_result = i_rdata;
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/ls_ctrl.sv
// Load/store execution stage: one memory op in flight, result broadcast on LS CDB.
module ls_ctrl
    import ls_ctrl_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      refresh_rob_cdb_in,
    ls_ctrl_if.master bus
);
    state_t                r_state;
    state_t                w_nstate;
    op_t                   r_op;
    logic [ROB_WIDTH-1:0]  r_rob;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic                  r_wr;
    logic                  r_valid;
    logic                  r_cdb_rdy;
    logic [DATA_WIDTH-1:0] r_result;
    logic [ROB_WIDTH-1:0]  r_cdb_rob;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_complete;

    assign w_accept = (r_state == S_IDLE) && bus.rdy_lsb_in
                      && !refresh_rob_cdb_in;
    assign w_done = (r_state != S_IDLE) && bus.done_mc_in;
    // A flushed op still finishes its memory transaction but never reaches the CDB.
    assign w_complete = w_done && (r_state == S_BUSY)
                        && !refresh_rob_cdb_in;

    ls_ctrl_extend u_extend (
        .i_op     (r_op),
        .i_rdata  (bus.rdata_mc_in),
        .o_result (w_ext)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            r_state <= S_IDLE;
        else if (rdy_in)
            r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:
                if (bus.rdy_lsb_in && !refresh_rob_cdb_in)
                    w_nstate = S_BUSY;
            S_BUSY:
                if (bus.done_mc_in)
                    w_nstate = S_IDLE;
                else if (refresh_rob_cdb_in)
                    w_nstate = S_FLUSH;
            S_FLUSH:
                if (bus.done_mc_in)
                    w_nstate = S_IDLE;
            default:
                w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_op      <= '0;
            r_rob     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_wr      <= FALSE;
            r_valid   <= FALSE;
            r_cdb_rdy <= FALSE;
            r_result  <= '0;
            r_cdb_rob <= '0;
        end else if (rdy_in) begin
            r_cdb_rdy <= FALSE;
            if (w_accept) begin
                r_op    <= bus.opcode_lsb_in;
                r_rob   <= bus.rob_id_lsb_in;
                r_addr  <= bus.vj_lsb_in + bus.imm_lsb_in;
                r_wdata <= bus.vk_lsb_in;
                r_size  <= op_size(bus.opcode_lsb_in);
                r_wr    <= is_store(bus.opcode_lsb_in);
                r_valid <= TRUE;
            end
            if (w_done)
                r_valid <= FALSE;
            if (w_complete) begin
                r_cdb_rdy <= TRUE;
                r_result  <= w_ext;
                r_cdb_rob <= r_rob;
            end
        end
    end

    always_comb begin
        bus.idle_lsb_out   = (r_state == S_IDLE);
        bus.valid_mc_out   = r_valid;
        bus.wr_mc_out      = r_wr;
        bus.addr_mc_out    = r_addr;
        bus.size_mc_out    = r_size;
        bus.wdata_mc_out   = r_wdata;
        bus.rdy_cdb_out    = r_cdb_rdy && !(rdy_in && refresh_rob_cdb_in);
        bus.result_cdb_out = r_result;
        bus.rob_id_cdb_out = r_cdb_rob;
    end
endmodule

// File: tb/tb_ls_ctrl.sv
// Directed plus randomized checks of ls_ctrl against a transaction-level model.
module tb_ls_ctrl;
    import ls_ctrl_pkg::*;

    logic clk;
    logic rst_in;
    logic rdy_in;
    logic refresh;
    int   n_chk;
    int   n_pass;

    ls_ctrl_if bus ();

    ls_ctrl dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .refresh_rob_cdb_in (refresh),
        .bus                (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // LSBuffer must only issue while the stage reports idle.
    always @(posedge clk) begin
        if (rst_in && rdy_in && bus.rdy_lsb_in) begin
            n_chk++;
            assert (bus.idle_lsb_out === 1'b1) n_pass++;
            else $error("FAIL lsb_protocol: observed idle %b expected 1",
                        bus.idle_lsb_out);
        end
    end

    function automatic logic m_store(op_t op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [1:0] m_size(op_t op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
        return 2'd3;
    endfunction

    function automatic logic [31:0] m_pad(op_t op, logic [31:0] r);
        if (m_size(op) == 2'd0) return r % 256;
        if (m_size(op) == 2'd1) return r % 65536;
        return r;
    endfunction

    function automatic logic [31:0] m_result(op_t op, logic [31:0] r);
        longint v;
        v = 0;
        if (op == OP_LB) begin
            v = r % 256;
            if (v >= 128) v = v - 256;
        end else if (op == OP_LH) begin
            v = r % 65536;
            if (v >= 32768) v = v - 65536;
        end else if (op == OP_LBU) begin
            v = r % 256;
        end else if (op == OP_LHU) begin
            v = r % 65536;
        end else if (op == OP_LW) begin
            v = r;
        end
        return v[31:0];
    endfunction

    task automatic issue(input op_t op, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [31:0] imm,
                         input logic [3:0] rob);
        bus.rdy_lsb_in    = 1'b1;
        bus.opcode_lsb_in = op;
        bus.vj_lsb_in     = vj;
        bus.vk_lsb_in     = vk;
        bus.imm_lsb_in    = imm;
        bus.rob_id_lsb_in = rob;
        tick();
        bus.rdy_lsb_in    = 1'b0;
        bus.vj_lsb_in     = $urandom;
        bus.vk_lsb_in     = $urandom;
        bus.imm_lsb_in    = $urandom;
        bus.rob_id_lsb_in = 4'($urandom);
    endtask

    // One full op; fc is the BUSY cycle carrying refresh (-1 none).
    task automatic run_op(input op_t op, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] imm,
                          input logic [3:0] rob, input int lat,
                          input int fc, input bit kill,
                          input logic [31:0] raw);
        logic [31:0] ea;
        logic [31:0] rd;
        bit          fl;
        ea = vj + imm;
        rd = m_pad(op, raw);
        fl = 1'b0;
        chk("idle_before", bus.idle_lsb_out, 1);
        issue(op, vj, vk, imm, rob);
        chk("idle_busy", bus.idle_lsb_out, 0);
        chk("wr", bus.wr_mc_out, m_store(op));
        chk("size", bus.size_mc_out, m_size(op));
        chk("wdata", bus.wdata_mc_out, vk);
        for (int c = 0; c <= lat; c++) begin
            chk("valid_held", bus.valid_mc_out, 1);
            chk("addr", bus.addr_mc_out, ea);
            chk("cdb_quiet", bus.rdy_cdb_out, 0);
            refresh = (c == fc);
            if (c == fc) fl = 1'b1;
            bus.done_mc_in  = (c == lat);
            bus.rdata_mc_in = (c == lat) ? rd : $urandom;
            tick();
        end
        refresh = 1'b0;
        bus.done_mc_in = 1'b0;
        chk("valid_drop", bus.valid_mc_out, 0);
        chk("cdb_pulse", bus.rdy_cdb_out, !fl);
        if (!fl) begin
            chk("cdb_result", bus.result_cdb_out, m_result(op, rd));
            chk("cdb_rob", bus.rob_id_cdb_out, rob);
            if (kill) begin
                refresh = 1'b1;
                #1;
                chk("cdb_kill", bus.rdy_cdb_out, 0);
                refresh = 1'b0;
            end
        end
        tick();
        chk("cdb_once", bus.rdy_cdb_out, 0);
        chk("idle_after", bus.idle_lsb_out, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, bus.valid_mc_out, 0);
        chk({tag, "_wr"}, bus.wr_mc_out, 0);
        chk({tag, "_addr"}, bus.addr_mc_out, 0);
        chk({tag, "_size"}, bus.size_mc_out, 0);
        chk({tag, "_wdata"}, bus.wdata_mc_out, 0);
        chk({tag, "_cdb"}, bus.rdy_cdb_out, 0);
        chk({tag, "_result"}, bus.result_cdb_out, 0);
        chk({tag, "_rob"}, bus.rob_id_cdb_out, 0);
        chk({tag, "_idle"}, bus.idle_lsb_out, 1);
    endtask

    initial begin
        op_t ops[8];
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        n_chk = 0;
        n_pass = 0;
        rst_in = 1'b0;
        rdy_in = 1'b0;
        refresh = 1'b0;
        bus.rdy_lsb_in = 1'b0;
        bus.opcode_lsb_in = OP_LW;
        bus.vj_lsb_in = '0;
        bus.vk_lsb_in = '0;
        bus.imm_lsb_in = '0;
        bus.rob_id_lsb_in = '0;
        bus.done_mc_in = 1'b0;
        bus.rdata_mc_in = '0;

        repeat (3) tick();
        chk_reset_state("rst");
        rst_in = 1'b1;
        rdy_in = 1'b1;
        tick();

        run_op(OP_LW, 32'h1000, 32'h0, 32'h4, 4'd3, 3, -1, 0, 32'hDEADBEEF);
        run_op(OP_LB, 32'h100, 32'h0, 32'h0, 4'd1, 1, -1, 0, 32'h80);
        run_op(OP_LBU, 32'h100, 32'h0, 32'h0, 4'd2, 0, -1, 0, 32'h80);
        run_op(OP_LH, 32'h200, 32'h0, 32'h2, 4'd4, 2, -1, 0, 32'h8001);
        run_op(OP_SH, 32'h20, 32'h12345678, 32'hFFFFFFFE, 4'd7, 2, -1, 0, 32'h0);
        run_op(OP_LW, 32'h300, 32'h0, 32'h0, 4'd6, 4, 1, 0, 32'h55AA55AA);
        run_op(OP_SW, 32'h300, 32'h99, 32'h8, 4'd8, 2, 2, 0, 32'h0);
        run_op(OP_LHU, 32'h400, 32'h0, 32'h0, 4'd9, 1, -1, 1, 32'hF00D);

        // Done while idle must not start anything.
        bus.done_mc_in = 1'b1;
        tick();
        bus.done_mc_in = 1'b0;
        chk("idle_done_valid", bus.valid_mc_out, 0);
        chk("idle_done_cdb", bus.rdy_cdb_out, 0);

        // Issue coinciding with refresh is discarded.
        refresh = 1'b1;
        issue(OP_LW, 32'h10, 32'h0, 32'h0, 4'd5);
        refresh = 1'b0;
        chk("discard_valid", bus.valid_mc_out, 0);
        chk("discard_idle", bus.idle_lsb_out, 1);
        tick();
        chk("discard_cdb", bus.rdy_cdb_out, 0);

        // Global stall mid-transaction and across the CDB pulse.
        issue(OP_LW, 32'h40, 32'h0, 32'h8, 4'd5);
        rdy_in = 1'b0;
        refresh = 1'b1;
        repeat (4) begin
            tick();
            chk("frz_valid", bus.valid_mc_out, 1);
            chk("frz_addr", bus.addr_mc_out, 32'h48);
            chk("frz_idle", bus.idle_lsb_out, 0);
        end
        rdy_in = 1'b1;
        refresh = 1'b0;
        bus.done_mc_in = 1'b1;
        bus.rdata_mc_in = 32'h11223344;
        tick();
        bus.done_mc_in = 1'b0;
        chk("frz_drop", bus.valid_mc_out, 0);
        chk("frz_cdb", bus.rdy_cdb_out, 1);
        rdy_in = 1'b0;
        repeat (2) begin
            tick();
            chk("frz_cdb_hold", bus.rdy_cdb_out, 1);
            chk("frz_cdb_res", bus.result_cdb_out, 32'h11223344);
        end
        rdy_in = 1'b1;
        tick();
        chk("frz_cdb_end", bus.rdy_cdb_out, 0);

        // Reset in the middle of a store.
        issue(OP_SW, 32'h80, 32'hCAFE, 32'h4, 4'd3);
        chk("pre_rst_valid", bus.valid_mc_out, 1);
        rst_in = 1'b0;
        rdy_in = 1'b0;
        tick();
        chk_reset_state("midrst");
        rst_in = 1'b1;
        rdy_in = 1'b1;
        tick();

        for (int i = 0; i < 30; i++) begin
            int lat;
            int fc;
            lat = int'($urandom_range(0, 4));
            fc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat)) : -1;
            run_op(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                   4'($urandom_range(1, 15)), lat, fc,
                   $urandom_range(0, 4) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
